uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, frame payload width; only 8 is required to be supported.
REQ-002 clk  input  1  system clock; all sequential logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; clock clk.
REQ-004 P_DATA  input  8  parallel byte to transmit.
REQ-005 DATA_VALID  input  1  P_DATA is valid; the byte is accepted only when ready=1 in the same cycle.
REQ-006 PAR_EN  input  1  1 = parity bit inserted after the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 prescale  input  6  clk cycles per serial bit; 0 encodes 64.
REQ-009 TX_OUT  output  1  serial line, registered, idle high.
REQ-010 ready  output  1  block can accept a byte this cycle.
REQ-011 busy  output  1  a frame is on the line.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Accept SHALL occur on a rising edge where DATA_VALID=1 and ready=1.
- Accept captures P_DATA, PAR_EN, PAR_TYP and prescale into internal registers.
- Later changes to these inputs SHALL NOT affect the frame in progress.
REQ-015 DATA_VALID while ready=0 SHALL be ignored; the block has no queueing.
REQ-016 ready SHALL be 1 in IDLE and in the last cycle of STOP; it is 0 otherwise.
REQ-017 The cycle after accept SHALL enter START with TX_OUT=0 and busy=1.
REQ-018 Every bit SHALL hold TX_OUT for exactly P cycles.
- P = captured prescale, or 64 when the captured prescale is 0.
- The edge counter runs 0..P-1; the bit counter advances when the edge counter reaches P-1.
REQ-019 Frame order SHALL be: start(0), data bits MSB first (bit7..bit0), parity (only if PAR_EN), stop(1).
- MSB-first order matches the team's rx deserializer, which shifts left.
REQ-020 Parity value SHALL be ^data for even parity and ~^data for odd parity.
REQ-021 State transitions, each taken at edge counter = P-1:
- START -> DATA.
- DATA -> PARITY after 8 bits when PAR_EN=1; DATA -> STOP after 8 bits when PAR_EN=0.
- PARITY -> STOP.
- STOP -> START if an accept occurs in that cycle, otherwise STOP -> IDLE.
REQ-022 Frame length SHALL be 11*P cycles with parity and 10*P cycles without.
REQ-023 frame_done SHALL pulse for 1 cycle, registered, in the cycle after the last STOP cycle.
REQ-024 Back-to-back accept in the last STOP cycle SHALL start the next start bit with zero idle cycles; frame_done still pulses.
REQ-025 In IDLE: TX_OUT=1, busy=0.
REQ-026 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 On rst=1 the block SHALL immediately, without waiting for clk, set:
- state IDLE; counters 0;
- TX_OUT=1, busy=0, frame_done=0;
- ready=1 as soon as rst is released.
REQ-028 Reset mid-frame SHALL abort the frame with no partial bits afterwards; the first accept after release starts a fresh frame.

Verification
REQ-029 0xA5, prescale=8, PAR_EN=1, PAR_TYP=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, each held 8 cycles; 88 cycles total; one frame_done pulse.
REQ-030 0x01, prescale=4, PAR_EN=1, PAR_TYP=1 -> parity bit 0; frame 0,0000000,1,0,1; 44 cycles.
REQ-031 0xFF, prescale=0, PAR_EN=0 -> 64 cycles per bit, 640 cycles total, no parity bit.
REQ-032 Two bytes 0x3C then 0xC3, with DATA_VALID held high -> second start bit begins the cycle after the first stop ends; ready pulses high for exactly 1 cycle between frames.
REQ-033 rst asserted during the data bits -> TX_OUT=1 and busy=0 immediately; a new byte afterwards yields a correct full frame.
REQ-034 Loopback of TX_OUT into rx with the same prescale and parity settings, random bytes -> rx P_DATA equals the sent byte, data_valid=1, no errors.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a byte producer and uart_tx.
// The producer drives the byte and frame options; uart_tx drives the line and status.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            prescale;
    logic                  TX_OUT;
    logic                  ready;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        output prescale,
        input  TX_OUT,
        input  ready,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        input  prescale,
        output TX_OUT,
        output ready,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data MSB first, optional parity, one stop bit.
// Every bit lasts P clk cycles, P = captured prescale (0 means 64).
// All outputs are registered; a byte offered in the last stop cycle starts the
// next frame with no idle gap.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    // Holds P-1, so prescale 0 wraps to 63 and yields a 64-cycle bit.
    logic [5:0]            pm1_q, pm1_d;
    logic [BitCntW-1:0]    bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  accept;
    logic                  last_cnt;
    logic                  load;

    assign accept   = bus.DATA_VALID && ready_q;
    assign last_cnt = (cnt_q == pm1_q);

    // Next-state, capture and registered-output computation for the frame FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = last_cnt ? 6'd0 : cnt_q + 6'd1;
        pm1_d        = pm1_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = 6'd0;
                if (accept) begin
                    load    = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (last_cnt) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (last_cnt) begin
                    if (bit_q == LastBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d   = bit_q + BitCntW'(1);
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            StParity: begin
                if (last_cnt) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (last_cnt) begin
                    frame_done_d = 1'b1;
                    if (accept) begin
                        load    = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 6'd0;
            end
        endcase

        // Frame options are frozen here so later input changes cannot disturb the frame.
        if (load) begin
            cnt_d     = 6'd0;
            pm1_d     = bus.prescale - 6'd1;
            shift_d   = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_bit_d = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
        end

        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[DATA_WIDTH-1];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle) || ((state_d == StStop) && (cnt_d == pm1_d));
    end

    // State and output registers; reset forces an idle line without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 6'd0;
            pm1_q        <= 6'd0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            tx_q         <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pm1_q        <= pm1_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            tx_q         <= tx_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.TX_OUT     = tx_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, bit timing, back-to-back frames,
// asynchronous reset and a bench-side serial receiver.
module tb_uart_tx;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offer one byte at a negedge; returns at the next negedge (first START cycle).
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] presc);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.prescale   = presc;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    // Record nbits bits of p cycles each, first-sent bit ends up most significant.
    task automatic capture(input int p, input int nbits, output logic [10:0] bits,
                           output int hold_err, output int fd_cnt, output int rdy_cnt,
                           output int busy_low);
        logic cur;
        bits = '0; hold_err = 0; fd_cnt = 0; rdy_cnt = 0; busy_low = 0; cur = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                if (c == 0) begin
                    cur  = bus.TX_OUT;
                    bits = {bits[9:0], cur};
                end else if (bus.TX_OUT !== cur) begin
                    hold_err++;
                end
                if (bus.frame_done === 1'b1) fd_cnt++;
                if (bus.ready === 1'b1) rdy_cnt++;
                if (bus.busy !== 1'b1) busy_low++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.DATA_VALID = 1'b0; bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0; bus.prescale = 6'd1;
        #3;
        n_vec++; if (bus.TX_OUT !== 1'b1) begin n_err++;
            $display("FAIL rst_tx: got %b want 1", bus.TX_OUT); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++;
            $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_err++;
            $display("FAIL rst_frame_done: got %b want 0", bus.frame_done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (bus.ready !== 1'b1) begin n_err++;
            $display("FAIL rst_ready: got %b want 1", bus.ready); end
        @(negedge clk);
    endtask

    // 0xA5, P=8, even parity; inputs scrambled after accept must not matter.
    task automatic test_frame_a5();
        logic [10:0] bits; int he, fd, rd, bl;
        start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
        bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1; bus.prescale = 6'd1;
        capture(8, 11, bits, he, fd, rd, bl);
        n_vec++; if (bits !== 11'b0_10100101_0_1) begin n_err++;
            $display("FAIL a5_bits: got %b want %b", bits, 11'b0_10100101_0_1); end
        n_vec++; if (he !== 0) begin n_err++;
            $display("FAIL a5_hold: got %0d glitches want 0", he); end
        n_vec++; if (fd !== 0 || rd !== 1 || bl !== 0) begin n_err++;
            $display("FAIL a5_status: fd=%0d rdy=%0d busylow=%0d want 0 1 0", fd, rd, bl); end
        n_vec++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.TX_OUT !== 1'b1)
        begin n_err++;
            $display("FAIL a5_end: fd=%b busy=%b tx=%b want 1 0 1",
                     bus.frame_done, bus.busy, bus.TX_OUT); end
        @(negedge clk);
        n_vec++; if (bus.frame_done !== 1'b0) begin n_err++;
            $display("FAIL a5_fd_pulse: got %b want 0", bus.frame_done); end
    endtask

    task automatic test_frame_01();
        logic [10:0] bits; int he, fd, rd, bl;
        start_frame(8'h01, 1'b1, 1'b1, 6'd4);
        capture(4, 11, bits, he, fd, rd, bl);
        n_vec++; if (bits !== 11'b0_00000001_0_1 || he !== 0) begin n_err++;
            $display("FAIL x01_bits: got %b glitches=%0d want %b 0", bits, he,
                     11'b0_00000001_0_1); end
        n_vec++; if (bus.frame_done !== 1'b1 || bl !== 0 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL x01_len: fd=%b busylow=%0d busy=%b want 1 0 0",
                     bus.frame_done, bl, bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_frame_ff();
        logic [10:0] bits; int he, fd, rd, bl;
        start_frame(8'hFF, 1'b0, 1'b0, 6'd0);
        capture(64, 10, bits, he, fd, rd, bl);
        n_vec++; if (bits !== 11'b00_11111111_1 || he !== 0) begin n_err++;
            $display("FAIL xff_bits: got %b glitches=%0d want %b 0", bits, he,
                     11'b00_11111111_1); end
        n_vec++; if (bus.frame_done !== 1'b1 || bl !== 0 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL xff_len: fd=%b busylow=%0d busy=%b want 1 0 0",
                     bus.frame_done, bl, bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits; int he, fd, rd, bl;
        bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.prescale = 6'd2;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.P_DATA = 8'hC3;
        capture(2, 10, bits, he, fd, rd, bl);
        bus.DATA_VALID = 1'b0;
        n_vec++; if (bits !== 11'b00_00111100_1 || he !== 0) begin n_err++;
            $display("FAIL b2b_first_bits: got %b glitches=%0d want %b 0", bits, he,
                     11'b00_00111100_1); end
        n_vec++; if (rd !== 1) begin n_err++;
            $display("FAIL b2b_ready_pulse: got %0d cycles want 1", rd); end
        n_vec++; if (bus.frame_done !== 1'b1 || bus.TX_OUT !== 1'b0 || bus.busy !== 1'b1)
        begin n_err++;
            $display("FAIL b2b_gap: fd=%b tx=%b busy=%b want 1 0 1",
                     bus.frame_done, bus.TX_OUT, bus.busy); end
        capture(2, 10, bits, he, fd, rd, bl);
        n_vec++; if (bits !== 11'b00_11000011_1 || he !== 0 || fd !== 1 || bl !== 0)
        begin n_err++;
            $display("FAIL b2b_second: got %b glitches=%0d fd=%0d busylow=%0d want %b 0 1 0",
                     bits, he, fd, bl, 11'b00_11000011_1); end
        n_vec++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL b2b_end: fd=%b busy=%b want 1 0", bus.frame_done, bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits; int he, fd, rd, bl; int bad;
        start_frame(8'hA5, 1'b1, 1'b0, 6'd8);
        repeat (19) @(negedge clk);
        n_vec++; if (bus.TX_OUT !== 1'b0 || bus.busy !== 1'b1) begin n_err++;
            $display("FAIL rstmid_pre: tx=%b busy=%b want 0 1", bus.TX_OUT, bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL rstmid_async: tx=%b busy=%b want 1 0", bus.TX_OUT, bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.ready !== 1'b1) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
        start_frame(8'h5A, 1'b1, 1'b0, 6'd3);
        capture(3, 11, bits, he, fd, rd, bl);
        n_vec++; if (bits !== 11'b0_01011010_0_1 || he !== 0 || bus.frame_done !== 1'b1)
        begin n_err++;
            $display("FAIL rstmid_fresh: got %b glitches=%0d fd=%b want %b 0 1", bits, he,
                     bus.frame_done, 11'b0_01011010_0_1); end
        @(negedge clk);
    endtask

    // Mid-bit sampling receiver fed from TX_OUT.
    task automatic test_loopback();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d, rx;
            logic pe, pt, s, perr, stop_ok;
            int p, w;
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            p  = $urandom_range(2, 9);
            rx = '0; perr = 1'b0;
            start_frame(d, pe, pt, 6'(p));
            w = 0;
            while (bus.TX_OUT !== 1'b0 && w < 4 * p) begin
                @(negedge clk);
                w++;
            end
            n_vec++; if (w >= 4 * p) begin n_err++;
                $display("FAIL loop_start_%0d: no start bit within %0d cycles", i, 4 * p); end
            repeat (p / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (p) @(negedge clk);
                rx = {rx[6:0], bus.TX_OUT};
            end
            if (pe) begin
                repeat (p) @(negedge clk);
                s = bus.TX_OUT;
                perr = pt ? (s !== ~^rx) : (s !== ^rx);
            end
            repeat (p) @(negedge clk);
            stop_ok = (bus.TX_OUT === 1'b1);
            n_vec++; if (rx !== d || perr !== 1'b0 || stop_ok !== 1'b1) begin n_err++;
                $display("FAIL loop_byte_%0d: rx=%h perr=%b stop=%b want %h 0 1",
                         i, rx, perr, stop_ok, d); end
            w = 0;
            while (bus.busy !== 1'b0 && w < 2 * p) begin
                @(negedge clk);
                w++;
            end
            n_vec++; if (bus.busy !== 1'b0) begin n_err++;
                $display("FAIL loop_idle_%0d: busy=%b want 0", i, bus.busy); end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_frame_a5();
        test_frame_01();
        test_frame_ff();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
